shift_unit_iterative: RTL and testbench
=======================================

// Module: shift_unit_iterative
// PURPOSE
//  Multi-cycle shifter for the ALU shift instructions: sll, srl and sra.
//  Complements the fixed left-by-2 address shifters. Performs the right-shift direction plus a
//  variable left shift, one bit position per clock, under a start/busy/done handshake.
//  Sits beside the ALU. Control stalls the PC while busy_o is high.
// PARAMETERS
//  DATA_W   32  operand/result width
//  SHAMT_W   5  shift-amount width (log2 DATA_W)
// PORTS
//  clk_i    in   1        single clock, rising edge
//  rst_i    in   1        asynchronous, active-low reset
//  start_i  in   1        request; sampled only when accepting (IDLE or DONE)
//  op_i     in   2        00 SLL, 01 SRL, 10 SRA, 11 pass-through
//  data_i   in   DATA_W   operand, captured with start
//  shamt_i  in   SHAMT_W  shift amount, captured with start
//  busy_o   out  1        high while in SHIFT
//  done_o   out  1        one-cycle pulse, result valid
//  data_o   out  DATA_W   working/result register
// BEHAVIOUR
//  Reset (rst_i=0, async): state IDLE, busy_o=0, done_o=0, data_o=0, count=0, op reg=00.
//  States: IDLE, SHIFT, DONE.
//   IDLE : start_i=1 -> load data_o<=data_i, cnt<=shamt_i, op<=op_i -> SHIFT.
//          For op 11, load cnt<=0.
//   SHIFT: cnt==0 -> DONE; else shift data_o by 1 and decrement cnt.
//          SLL: {d[W-2:0],0}. SRL: {0,d[W-1:1]}. SRA: {d[W-1],d[W-1:1]}.
//   DONE : done_o=1 for exactly this cycle.
//          start_i=1 -> load as in IDLE -> SHIFT (back-to-back); else -> IDLE.
//  Latency: start sampled at edge k.
//   done_o is high in the cycle after edge k+N+1 (N = captured shamt; N=0 -> after edge k+1).
//  start_i while in SHIFT is ignored; data_i, shamt_i and op_i are not captured.
//  data_o changes during SHIFT; it is valid when done_o=1.
//   After that it holds until the next accepted start.
//  SRA sign fill uses the current MSB of data_o. The MSB never changes under SRA,
//   so it always equals the original sign.
//  shamt=DATA_W-1 is the maximum; the count never wraps.
//  Reset mid-operation: outputs clear at once and no done_o pulse is issued for the aborted op.
//  busy_o and done_o are never high together.
// STRUCTURE
//  Shared package shift_pkg: op encodings SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10,
//   SH_PASS=2'b11, and state encodings S_IDLE/S_SHIFT/S_DONE.
//  One natural sub-module: shift_step_1, a combinational single-bit step (op, d -> d').
//  The FSM, counter and data register live in the top module.
// TESTING
//  SLL: data=32'h0000_0001, shamt=4 -> done_o after edge k+5, data_o=32'h0000_0010,
//   busy_o high for 5 cycles.
//  SRA: data=32'h8000_0000, shamt=31 -> done_o after edge k+32, data_o=32'hFFFF_FFFF.
//  SRL: data=32'h8000_0000, shamt=31 -> data_o=32'h0000_0001.
//   Also SRL with shamt=0 on 32'hDEADBEEF -> done_o after edge k+1, data_o=32'hDEADBEEF.
//  Ignore-while-busy: start SRL 32'hF0 shamt=4.
//   Re-assert start with 32'h1 shamt=1 during SHIFT -> result 32'h0F, one done_o pulse only.
//   Then assert start (SLL 32'h3, shamt=1) in the DONE cycle -> accepted, next result 32'h6.
//  Reset mid-shift: rst_i=0 at cycle 3 of a shamt=10 op -> busy_o=0, data_o=0 immediately.
//   No done_o pulse; after release, a new op (SLL 32'h1, shamt=1 -> 32'h2) completes normally.
//  op=11 with shamt=7 on 32'h1234_5678 -> done_o after edge k+1, data_o unchanged.

Source files
------------

// File: rtl/shift_pkg.sv
// Purpose : shared encodings for the iterative shifter (op codes, FSM states).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package shift_pkg;

   // ALU shift operation encodings as presented on op_i.
   typedef enum logic [1:0] {
      SH_SLL  = 2'b00,
      SH_SRL  = 2'b01,
      SH_SRA  = 2'b10,
      SH_PASS = 2'b11
   } sh_op_t;

   // Control FSM states of the iterative shifter.
   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } sh_state_t;

endpackage : shift_pkg

// File: rtl/shift_step_1.sv
// Purpose : combinational single-bit shift step (one position per call).
// Latency : 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports   : i_op   - shift operation (sh_op_t)
//           i_data - current working value
//           o_data - value after one SLL/SRL/SRA step, or unchanged for pass
module shift_step_1
   import shift_pkg::*;
#(
   parameter int DATA_W = 32
)
(
   input  sh_op_t            i_op,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data
);

   always_comb begin
      o_data = i_data;
      case (i_op)
         SH_SLL:  o_data = {i_data[DATA_W-2:0], 1'b0};
         SH_SRL:  o_data = {1'b0, i_data[DATA_W-1:1]};
         // Sign fill from the current MSB; SRA never alters the MSB, so it
         // stays equal to the original operand sign for every step.
         SH_SRA:  o_data = {i_data[DATA_W-1], i_data[DATA_W-1:1]};
         default: o_data = i_data;
      endcase
   end

endmodule : shift_step_1

// File: rtl/shift_unit_iterative.sv
// Purpose : multi-cycle SLL/SRL/SRA shifter, one bit per clock, start/busy/done handshake.
// Latency : done_o high in the cycle after edge k+N+1 (start at edge k, N = captured shamt).
// Backpressure: start_i accepted only in IDLE or DONE; ignored while busy_o is high.
// Ports   : clk_i   - clock, rising edge
//           rst_i   - asynchronous active-low reset
//           start_i - request, sampled when idle or in the done cycle
//           op_i    - 00 SLL, 01 SRL, 10 SRA, 11 pass-through
//           data_i  - operand, captured with an accepted start
//           shamt_i - shift amount, captured with an accepted start
//           busy_o  - high while shifting
//           done_o  - one-cycle pulse, data_o holds the result
//           data_o  - working/result register, held after done until next start
module shift_unit_iterative
   import shift_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
)
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [1:0]         op_i,
   input  logic [DATA_W-1:0]  data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [DATA_W-1:0]  data_o
);

   sh_state_t          r_state;
   sh_op_t             r_op;
   logic [SHAMT_W-1:0] r_cnt;
   logic [DATA_W-1:0]  r_data;
   logic               r_busy;
   logic               r_done;

   logic               w_accept;
   sh_op_t             w_op_in;
   logic [DATA_W-1:0]  w_step;

   assign w_op_in  = sh_op_t'(op_i);
   // New work is taken only when no shift is in flight; the DONE cycle also
   // accepts so that operations can run back to back.
   assign w_accept = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

   shift_step_1 #(
      .DATA_W (DATA_W)
   ) u_step (
      .i_op   (r_op),
      .i_data (r_data),
      .o_data (w_step)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_op    <= SH_SLL;
         r_cnt   <= '0;
         r_data  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (w_accept) begin
         r_state <= S_SHIFT;
         r_op    <= w_op_in;
         // Pass-through skips straight to completion with zero steps.
         r_cnt   <= (w_op_in == SH_PASS) ? '0 : shamt_i;
         r_data  <= data_i;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_SHIFT: begin
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_data  <= w_step;
                  r_cnt   <= r_cnt - SHAMT_W'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o = r_busy;
   assign done_o = r_done;
   assign data_o = r_data;

endmodule : shift_unit_iterative

// File: tb/tb_shift_unit_iterative.sv
// Purpose : directed self-checking bench for shift_unit_iterative.
// Latency : n/a.
// Backpressure: n/a.
module tb_shift_unit_iterative;

   logic        clk_i;
   logic        rst_i;
   logic        start_i;
   logic [1:0]  op_i;
   logic [31:0] data_i;
   logic [4:0]  shamt_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] data_o;

   int n_chk  = 0;
   int n_fail = 0;

   shift_unit_iterative #(
      .DATA_W  (32),
      .SHAMT_W (5)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .op_i    (op_i),
      .data_i  (data_i),
      .shamt_i (shamt_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .data_o  (data_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Issue one op, then measure edges from acceptance to done, busy cycles,
   // result, busy/done overlap, and that the result holds after the pulse.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [31:0] exp_d, input int exp_lat);
      int lat;
      int busy_cyc;
      bit overlap;
      @(posedge clk_i); #1;
      start_i = 1'b1; op_i = op; data_i = d; shamt_i = sh;
      @(posedge clk_i); #1;                    // edge k has sampled start
      start_i = 1'b0; op_i = 2'b00; data_i = '0; shamt_i = '0;
      lat = -1; busy_cyc = 0; overlap = 1'b0;
      for (int j = 0; j < 64; j++) begin
         if (busy_o) busy_cyc++;
         if (busy_o && done_o) overlap = 1'b1;
         if (done_o) begin
            lat = j;
            break;
         end
         @(posedge clk_i); #1;
      end
      n_chk++;
      if (lat !== exp_lat) begin
         n_fail++; $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
      end
      n_chk++;
      if (data_o !== exp_d) begin
         n_fail++; $display("FAIL %s result: got %h, expected %h", name, data_o, exp_d);
      end
      n_chk++;
      if (busy_cyc !== exp_lat) begin
         n_fail++; $display("FAIL %s busy cycles: got %0d, expected %0d", name, busy_cyc, exp_lat);
      end
      n_chk++;
      if (overlap !== 1'b0) begin
         n_fail++; $display("FAIL %s busy/done overlap: got %b, expected 0", name, overlap);
      end
      @(posedge clk_i); #1;
      n_chk++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL %s pulse width: done=%b busy=%b, expected 0 0", name, done_o, busy_o);
      end
      n_chk++;
      if (data_o !== exp_d) begin
         n_fail++; $display("FAIL %s hold: got %h, expected %h", name, data_o, exp_d);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; data_i = '0; shamt_i = '0;
      #1 rst_i = 1'b0;
      #1;
      n_chk++;
      if ({busy_o, done_o, data_o} !== 34'h0) begin
         n_fail++; $display("FAIL reset async: busy=%b done=%b data=%h, expected 0 0 0", busy_o, done_o, data_o);
      end
      start_i = 1'b1; data_i = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk_i);
      #1;
      n_chk++;
      if ({busy_o, done_o, data_o} !== 34'h0) begin
         n_fail++; $display("FAIL reset held: busy=%b done=%b data=%h, expected 0 0 0", busy_o, done_o, data_o);
      end
      start_i = 1'b0; data_i = '0;
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_sll();
      run_op("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010, 5);
   endtask

   task automatic test_sra();
      run_op("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32);
   endtask

   task automatic test_srl();
      run_op("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 32);
      run_op("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
   endtask

   task automatic test_pass();
      run_op("pass7", 2'b11, 32'h1234_5678, 5'd7, 32'h1234_5678, 1);
   endtask

   task automatic test_back_to_back();
      int lat;
      int dones;
      @(posedge clk_i); #1;
      start_i = 1'b1; op_i = 2'b01; data_i = 32'h0000_00F0; shamt_i = 5'd4;
      @(posedge clk_i); #1;                    // edge k
      start_i = 1'b0;
      lat = -1; dones = 0;
      for (int j = 0; j < 40; j++) begin
         if (j == 1) begin
            start_i = 1'b1; op_i = 2'b01; data_i = 32'h0000_0001; shamt_i = 5'd1;
         end
         if (j == 3) start_i = 1'b0;
         if (done_o) begin
            dones++;
            lat = j;
            break;
         end
         @(posedge clk_i); #1;
      end
      n_chk++;
      if (lat !== 5) begin
         n_fail++; $display("FAIL busy_ignore latency: got %0d edges, expected 5", lat);
      end
      n_chk++;
      if (data_o !== 32'h0000_000F) begin
         n_fail++; $display("FAIL busy_ignore result: got %h, expected 0000000f", data_o);
      end
      // Start presented in the DONE cycle must be taken.
      start_i = 1'b1; op_i = 2'b00; data_i = 32'h0000_0003; shamt_i = 5'd1;
      @(posedge clk_i); #1;
      start_i = 1'b0; data_i = '0; shamt_i = '0;
      n_chk++;
      if (busy_o !== 1'b1 || done_o !== 1'b0) begin
         n_fail++; $display("FAIL b2b accept: busy=%b done=%b, expected 1 0", busy_o, done_o);
      end
      lat = -1;
      for (int j = 0; j < 40; j++) begin
         if (done_o) begin
            dones++;
            lat = j;
            break;
         end
         @(posedge clk_i); #1;
      end
      n_chk++;
      if (lat !== 2 || dones !== 2) begin
         n_fail++; $display("FAIL b2b latency: got %0d edges (%0d pulses), expected 2 (2)", lat, dones);
      end
      n_chk++;
      if (data_o !== 32'h0000_0006) begin
         n_fail++; $display("FAIL b2b result: got %h, expected 00000006", data_o);
      end
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset_mid_shift();
      bit seen_done;
      @(posedge clk_i); #1;
      start_i = 1'b1; op_i = 2'b00; data_i = 32'h0000_0001; shamt_i = 5'd10;
      @(posedge clk_i); #1;                    // edge k
      start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      n_chk++;
      if (busy_o !== 1'b1 || data_o !== 32'h0000_0008) begin
         n_fail++; $display("FAIL midrst pre: busy=%b data=%h, expected 1 00000008", busy_o, data_o);
      end
      rst_i = 1'b0;
      #1;
      n_chk++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || data_o !== 32'h0) begin
         n_fail++; $display("FAIL midrst clear: busy=%b done=%b data=%h, expected 0 0 0", busy_o, done_o, data_o);
      end
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      seen_done = 1'b0;
      for (int j = 0; j < 15; j++) begin
         @(posedge clk_i); #1;
         if (done_o || busy_o) seen_done = 1'b1;
      end
      n_chk++;
      if (seen_done !== 1'b0) begin
         n_fail++; $display("FAIL midrst no_done: got activity=%b, expected 0", seen_done);
      end
      run_op("after_rst", 2'b00, 32'h0000_0001, 5'd1, 32'h0000_0002, 2);
   endtask

   initial begin
      test_reset();
      test_sll();
      test_sra();
      test_srl();
      test_pass();
      test_back_to_back();
      test_reset_mid_shift();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_shift_unit_iterative
